// File: rtl/skinny_subcells_serial.sv
// skinny_subcells_serial: SKINNY-128 SubCells over 16 cells using SBOXES shared S-box lanes.
// Define SKINNY_SUBCELLS_CLEAR_EN to wipe the state register on the output handshake.

module skinny_sbox8_lut (
    input  logic [7:0] x,
    output logic [7:0] y
);

    // SKINNY S8 as four NOR/XOR rounds with bit permutations; the last round swaps bits 1 and 2.
    function automatic logic [7:0] sb_mix(input logic [7:0] v);
        logic [7:0] t;
        t = ~(((v >> 1) | v) >> 2);
        return v ^ (t & 8'h11);
    endfunction

    function automatic logic [7:0] sb_perm(input logic [7:0] v);
        return ((v & 8'h01) << 2) |
               ((v & 8'h06) << 5) |
               ((v & 8'h20) >> 5) |
               ((v & 8'hC8) >> 2) |
               ((v & 8'h10) >> 1);
    endfunction

    function automatic logic [7:0] sb_swap(input logic [7:0] v);
        return (v & 8'hF9) |
               ((v >> 1) & 8'h02) |
               ((v << 1) & 8'h04);
    endfunction

    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] r3;

    always_comb begin
        r1 = sb_perm(sb_mix(x));
        r2 = sb_perm(sb_mix(r1));
        r3 = sb_perm(sb_mix(r2));
        y  = sb_swap(sb_mix(r3));
    end

endmodule

module skinny_subcells_serial #(
    parameter int SBOXES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int N  = 16 / SBOXES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = 8 * SBOXES;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    if (!(SBOXES == 1 || SBOXES == 2 || SBOXES == 4 ||
          SBOXES == 8 || SBOXES == 16)) begin : g_bad_sboxes
        $error("skinny_subcells_serial: SBOXES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } fsm_e;

    fsm_e           fsm_q;
    fsm_e           fsm_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic [127:0]   state_q;
    logic [127:0]   state_d;
    logic [LW-1:0]  sb_out;
    logic [127:0]   rot_next;

    for (genvar j = 0; j < SBOXES; j++) begin : g_lane
        skinny_sbox8_lut u_sbox (
            .x (state_q[127-8*j -: 8]),
            .y (sb_out[LW-1-8*j -: 8])
        );
    end

    // Left rotate by the lane width, substituted cells re-enter at the bottom.
    if (SBOXES == 16) begin : g_rot_full
        assign rot_next = sb_out;
    end else begin : g_rot_part
        assign rot_next = {state_q[127-LW:0], sb_out};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            cnt_q   <= '0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        unique case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = in_state;
                    cnt_d   = '0;
                    fsm_d   = S_RUN;
                end
            end
            S_RUN: begin
                state_d = rot_next;
                if (cnt_q == CNT_LAST) begin
                    fsm_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d = S_IDLE;
`ifdef SKINNY_SUBCELLS_CLEAR_EN
                    state_d = '0;
`endif
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (fsm_q == S_IDLE);
    assign out_valid = (fsm_q == S_DONE);
    assign busy      = (fsm_q == S_RUN) || (fsm_q == S_DONE);
    assign out_state = state_q;

endmodule

// File: tb/tb_skinny_subcells_serial.sv
// Directed bench for skinny_subcells_serial across all legal SBOXES widths.
module tb_skinny_subcells_serial;

    localparam int NI = 5;

    localparam logic [127:0] V0  = 128'h0;
    localparam logic [127:0] E0  = {16{8'h65}};
    localparam logic [127:0] V1  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] E1  = 128'h654C6A424B63436B55755A7A53735B7B;
    localparam logic [127:0] VF  = {16{8'hFF}};
    localparam logic [127:0] EF  = {16{8'hFF}};
    localparam logic [127:0] V10 = {16{8'h10}};
    localparam logic [127:0] E10 = {16{8'h35}};

    logic           clk = 1'b0;
    logic           rst;
    logic [NI-1:0]  iv;
    logic [NI-1:0]  ir;
    logic [NI-1:0]  ov;
    logic [NI-1:0]  ordy;
    logic [NI-1:0]  bz;
    logic [127:0]   ist [NI];
    logic [127:0]   ost [NI];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        skinny_subcells_serial #(.SBOXES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_state  (ist[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_state (ost[g]),
            .busy      (bz[g])
        );
    end

    task automatic do_load(input int k, input logic [127:0] v);
        iv[k]  = 1'b1;
        ist[k] = v;
        @(posedge clk);
        #1;
        iv[k]  = 1'b0;
    endtask

    task automatic wait_valid(input int k, output int cnt);
        cnt = 1;
        while (ov[k] !== 1'b1 && cnt < 64) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    task automatic do_accept(input int k);
        ordy[k] = 1'b1;
        @(posedge clk);
        #1;
        ordy[k] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || bz[k] !== 1'b0 ||
                ost[k] !== 128'h0) begin
                n_bad++;
                $display("FAIL reset[%0d]: got rdy=%b vld=%b busy=%b out=%h want 1 0 0 0",
                         k, ir[k], ov[k], bz[k], ost[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_zero;
        int cnt;
        do_load(0, V0);
        wait_valid(0, cnt);
        n_cmp++;
        if (cnt !== 17) begin
            n_bad++;
            $display("FAIL zero_latency: got %0d want 17", cnt);
        end
        n_cmp++;
        if (ost[0] !== E0) begin
            n_bad++;
            $display("FAIL zero_result: got %h want %h", ost[0], E0);
        end
        do_accept(0);
    endtask

    task automatic test_widths;
        int cnt;
        int lat;
        for (int k = 0; k < NI; k++) begin
            lat = (16 >> k) + 1;
            do_load(k, V1);
            n_cmp++;
            if (bz[k] !== 1'b1 || ir[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL run_flags[%0d]: got busy=%b rdy=%b want 1 0",
                         k, bz[k], ir[k]);
            end
            wait_valid(k, cnt);
            n_cmp++;
            if (cnt !== lat) begin
                n_bad++;
                $display("FAIL latency[%0d]: got %0d want %0d", k, cnt, lat);
            end
            n_cmp++;
            if (ost[k] !== E1) begin
                n_bad++;
                $display("FAIL result[%0d]: got %h want %h", k, ost[k], E1);
            end
            do_accept(k);
        end
    endtask

    task automatic test_stall;
        int cnt;
        do_load(0, VF);
        wait_valid(0, cnt);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || ost[0] !== EF) begin
                n_bad++;
                $display("FAIL stall[%0d]: got vld=%b rdy=%b out=%h want 1 0 %h",
                         i, ov[0], ir[0], ost[0], EF);
            end
            @(posedge clk);
            #1;
        end
        do_accept(0);
        n_cmp++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bz[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_release: got rdy=%b vld=%b busy=%b want 1 0 0",
                     ir[0], ov[0], bz[0]);
        end
    endtask

    task automatic test_reset_mid_run;
        int cnt;
        do_load(0, V1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bz[0] !== 1'b0 ||
            ost[0] !== 128'h0) begin
            n_bad++;
            $display("FAIL mid_reset: got rdy=%b vld=%b busy=%b out=%h want 1 0 0 0",
                     ir[0], ov[0], bz[0], ost[0]);
        end
        do_load(0, V10);
        wait_valid(0, cnt);
        n_cmp++;
        if (cnt !== 17 || ost[0] !== E10) begin
            n_bad++;
            $display("FAIL after_reset: got lat=%0d out=%h want 17 %h",
                     cnt, ost[0], E10);
        end
        do_accept(0);
    endtask

    task automatic test_toggle;
        int cnt;
        do_load(0, V1);
        for (int i = 0; i < 8; i++) begin
            iv[0]  = ~iv[0];
            ist[0] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
        end
        iv[0] = 1'b0;
        wait_valid(0, cnt);
        n_cmp++;
        if (ov[0] !== 1'b1 || ost[0] !== E1) begin
            n_bad++;
            $display("FAIL toggle: got vld=%b out=%h want 1 %h", ov[0], ost[0], E1);
        end
        do_accept(0);
    endtask

    task automatic test_clear;
        int cnt;
        logic [127:0] exp_idle;
`ifdef SKINNY_SUBCELLS_CLEAR_EN
        exp_idle = 128'h0;
`else
        exp_idle = E1;
`endif
        for (int k = 0; k < NI; k += 4) begin
            do_load(k, V1);
            wait_valid(k, cnt);
            do_accept(k);
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (ir[k] !== 1'b1 || ost[k] !== exp_idle) begin
                    n_bad++;
                    $display("FAIL idle_out[%0d.%0d]: got rdy=%b out=%h want 1 %h",
                             k, i, ir[k], ost[k], exp_idle);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        iv   = '0;
        ordy = '0;
        for (int k = 0; k < NI; k++) ist[k] = '0;
        test_reset;
        test_zero;
        test_widths;
        test_stall;
        test_reset_mid_run;
        test_toggle;
        test_clear;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
